// File: rtl/flowing_led_pkg.sv
// -----------------------------------------------------------------------------
// flowing_led_pkg
// Shared encodings for the flowing LED sequencer: requested pattern modes,
// pattern FSM states and ping-pong travel direction, plus a width helper.
// No ports; imported by flowing_led_sequencer and led_step_timer.
// -----------------------------------------------------------------------------
package flowing_led_pkg;

    // Pattern modes, encoded exactly as presented on the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_SHL  = 2'd0,   // running light towards higher indices
        MODE_SHR  = 2'd1,   // running light towards lower indices
        MODE_PING = 2'd2,   // bounce between the two end LEDs
        MODE_ALL  = 2'd3    // every LED blinks together
    } mode_e;

    // Pattern FSM states. ST_STOP drains the current step before idling.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    // Ping-pong travel direction; LEFT means increasing LED index.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Bit width needed to hold 0..v-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// -----------------------------------------------------------------------------
// led_step_timer
// Shared step timebase for the LED sequencer. Counts 0..STEP_CYC-1 while
// run_i is high and holds at zero otherwise.
//
// Ports:
//   clk_i        in   system clock
//   rst_i        in   asynchronous active-high reset
//   run_i        in   1 = count (sequencer busy), 0 = hold counter at zero
//   step_pulse_o out  high on the last cycle of each step while running
//   on_window_o  out  high while running and the counter is below ON_CYC
// -----------------------------------------------------------------------------
module led_step_timer
    import flowing_led_pkg::*;
#(
    parameter int unsigned STEP_CYC = 5_000_000,
    parameter int unsigned ON_CYC   = 1_250_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic step_pulse_o,
    output logic on_window_o
);

    localparam int unsigned    CW     = clog2_min1(STEP_CYC);
    localparam logic [CW-1:0]  LAST   = CW'(STEP_CYC - 1);
    // Any ON_CYC at or beyond the step length means solid-on, so clamp it to
    // STEP_CYC; that value always fits the CW+1 bit compare.
    localparam int unsigned    ON_LIM = (ON_CYC >= STEP_CYC) ? STEP_CYC : ON_CYC;
    localparam logic [CW:0]    ON_CMP = (CW + 1)'(ON_LIM);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (a latch).
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_pulse_o = run_i && (cnt_q == LAST);
    assign on_window_o  = run_i && ({1'b0, cnt_q} < ON_CMP);

endmodule

// File: rtl/flowing_led_sequencer.sv
// -----------------------------------------------------------------------------
// flowing_led_sequencer
// Drives N_LED outputs through running-light patterns on a fixed step period
// from a single shared timebase (led_step_timer). A three-state FSM starts and
// drains the sequence; mode changes arrive over a valid/ready handshake and are
// applied only at step boundaries (or straight away when idle).
//
// Optional feature: define FLOWING_LED_PWM_EN to add a duty[3:0] input and a
// free-running 4-bit PWM counter that dims lit LEDs inside the on-window.
//
// Ports:
//   CLK         in   system clock
//   RST         in   asynchronous active-high reset
//   en          in   level: 1 = run, 0 = stop at the end of the current step
//   mode[1:0]   in   requested pattern (see flowing_led_pkg::mode_e)
//   mode_vld    in   mode request valid
//   duty[3:0]   in   PWM duty, lit while pwm < duty (FLOWING_LED_PWM_EN only)
//   mode_rdy    out  a mode request can be accepted
//   LED_out     out  registered LED drive, 1 = lit
//   step_pulse  out  one-cycle pulse on the last cycle of each step
//   busy        out  high in RUN or STOPPING
// -----------------------------------------------------------------------------
module flowing_led_sequencer
    import flowing_led_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned STEP_CYC = 5_000_000,
    parameter int unsigned ON_CYC   = 1_250_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             mode_vld,
`ifdef FLOWING_LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic             mode_rdy,
    output logic [N_LED-1:0] LED_out,
    output logic             step_pulse,
    output logic             busy
);

    localparam int unsigned   PW       = clog2_min1(N_LED);
    localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);

    state_e           state_q, state_d;
    mode_e            cur_mode_q, cur_mode_d;
    mode_e            pend_mode_q, pend_mode_d;
    logic             pend_vld_q, pend_vld_d;
    logic [PW-1:0]    pos_q, pos_d;
    dir_e             dir_q, dir_d;
    logic [N_LED-1:0] led_q, led_d;

    logic             on_window;
    logic             accept;
    logic             apply;
    logic             pwm_on;
    logic [N_LED-1:0] pattern;

    assign busy = (state_q != ST_IDLE);

    led_step_timer #(
        .STEP_CYC (STEP_CYC),
        .ON_CYC   (ON_CYC)
    ) u_step_timer (
        .clk_i        (CLK),
        .rst_i        (RST),
        .run_i        (busy),
        .step_pulse_o (step_pulse),
        .on_window_o  (on_window)
    );

    // ------------------------------------------------------------------
    // Run/stop FSM. A returning en wins over the boundary in ST_STOP.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Mode handshake: one pending slot; ready is simply "slot empty", so a
    // request held off by ready low can never overwrite the pending one.
    // ------------------------------------------------------------------
    assign mode_rdy = !pend_vld_q;
    assign accept   = mode_vld && mode_rdy;
    assign apply    = pend_vld_q && ((state_q == ST_IDLE) || step_pulse);

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;
        if (apply) begin
            pend_vld_d = 1'b0;
        end else if (accept) begin
            pend_vld_d  = 1'b1;
            pend_mode_d = mode_e'(mode);
        end
    end

    // ------------------------------------------------------------------
    // Pattern position. Every completed step advances it, including the
    // step drained in ST_STOP, so a restart continues with the next LED.
    // ------------------------------------------------------------------
    always_comb begin
        cur_mode_d = cur_mode_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        if (apply) begin
            cur_mode_d = pend_mode_q;
            pos_d      = (pend_mode_q == MODE_SHR) ? POS_LAST : '0;
            dir_d      = DIR_LEFT;
        end else if (step_pulse) begin
            unique case (cur_mode_q)
                MODE_SHL: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                MODE_SHR: pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
                MODE_PING: begin
                    // Turn around on reaching an end and step back in the same
                    // move, so the end LED is shown only once per sweep.
                    if (POS_LAST != '0) begin
                        if (dir_q == DIR_LEFT) begin
                            if (pos_q == POS_LAST) begin
                                dir_d = DIR_RIGHT;
                                pos_d = pos_q - PW'(1);
                            end else begin
                                pos_d = pos_q + PW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_LEFT;
                                pos_d = PW'(1);
                            end else begin
                                pos_d = pos_q - PW'(1);
                            end
                        end
                    end
                end
                default: pos_d = pos_q;   // MODE_ALL ignores the position
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional PWM dimming inside the on-window.
    // ------------------------------------------------------------------
`ifdef FLOWING_LED_PWM_EN
    logic [3:0] pwm_q;
    logic [3:0] duty_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_q  <= '0;
            duty_q <= '0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
            // Track duty while idle so the first step uses the current value,
            // then only pick up changes on step boundaries.
            if (!busy || step_pulse) begin
                duty_q <= duty;
            end
        end
    end

    assign pwm_on = (pwm_q < duty_q);
`else
    assign pwm_on = 1'b1;
`endif

    // ------------------------------------------------------------------
    // LED drive: one-hot at pos, or all-ones, inside the on-window. The
    // state_d term blanks the pins as soon as a drained step finishes, even
    // when the on-window spans the whole step.
    // ------------------------------------------------------------------
    always_comb begin
        pattern = '0;
        if (cur_mode_q == MODE_ALL) begin
            pattern = '1;
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                pattern[i] = (pos_q == PW'(i));
            end
        end
    end

    always_comb begin
        led_d = '0;
        if (on_window && pwm_on && (state_d != ST_IDLE)) begin
            led_d = pattern;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cur_mode_q  <= MODE_SHL;
            pend_mode_q <= MODE_SHL;
            pend_vld_q  <= 1'b0;
            pos_q       <= '0;
            dir_q       <= DIR_LEFT;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_mode_q  <= cur_mode_d;
            pend_mode_q <= pend_mode_d;
            pend_vld_q  <= pend_vld_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            led_q       <= led_d;
        end
    end

    assign LED_out = led_q;

endmodule

// File: tb/tb_flowing_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flowing_led_sequencer
// Self-checking bench for flowing_led_sequencer (default build) with
// N_LED=4, STEP_CYC=10, ON_CYC=4. Expected values come from a step-level
// reference model: shift modes use modular arithmetic on the position,
// ping-pong folds a phase counter of period 2*N-2 onto the LED index.
// -----------------------------------------------------------------------------
module tb_flowing_led_sequencer;

    localparam int N    = 4;
    localparam int STEP = 10;
    localparam int ON   = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         en;
    logic [1:0]   mode;
    logic         mode_vld;
    logic         mode_rdy;
    logic [N-1:0] LED_out;
    logic         step_pulse;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_mode;
    int m_pos;
    int m_phase;
    int m_pend;
    bit m_rdy;

    flowing_led_sequencer #(
        .N_LED    (N),
        .STEP_CYC (STEP),
        .ON_CYC   (ON)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .mode       (mode),
        .mode_vld   (mode_vld),
        .mode_rdy   (mode_rdy),
        .LED_out    (LED_out),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] model_pattern();
        logic [N-1:0] one;
        one = 1;
        if (m_mode == 3) return '1;
        return one << m_pos;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pos   = 0;
        m_phase = 0;
        m_pend  = 0;
        m_rdy   = 1'b1;
    endtask

    task automatic model_apply();
        m_mode  = m_pend;
        m_pos   = (m_mode == 1) ? N - 1 : 0;
        m_phase = 0;
        m_rdy   = 1'b1;
    endtask

    task automatic model_advance();
        case (m_mode)
            0: m_pos = (m_pos + 1) % N;
            1: m_pos = (m_pos + N - 1) % N;
            2: begin
                m_phase = (m_phase + 1) % (2 * N - 2);
                m_pos   = (m_phase < N) ? m_phase : 2 * N - 2 - m_phase;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full step starting at cnt=0, checking every cycle against the model.
    task automatic run_step(input string tag,
                            input int req_at, input logic [1:0] req_mode,
                            input int junk_at, input logic [1:0] junk_mode,
                            input int stop_at, input int reen_at,
                            output logic [N-1:0] seen);
        logic [N-1:0] pat;
        logic [N-1:0] exp_led;
        bit           acc;
        bit           apply_now;
        pat  = model_pattern();
        seen = '0;
        for (int c = 0; c < STEP; c++) begin
            mode_vld = 1'b0;
            if (c == req_at) begin
                mode_vld = 1'b1;
                mode     = req_mode;
            end else if (c == junk_at) begin
                mode_vld = 1'b1;
                mode     = junk_mode;
            end
            if (c == stop_at) en = 1'b0;
            if (c == reen_at) en = 1'b1;
            exp_led = (c >= 1 && c <= ON) ? pat : '0;
            if (c == 1) seen = LED_out;
            n_checks++;
            if (LED_out !== exp_led) begin
                n_fail++;
                $display("FAIL %s led c=%0d: got %b expected %b", tag, c, LED_out, exp_led);
            end
            n_checks++;
            if (step_pulse !== (c == STEP - 1)) begin
                n_fail++;
                $display("FAIL %s step_pulse c=%0d: got %b expected %b", tag, c, step_pulse, c == STEP - 1);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy c=%0d: got %b expected 1", tag, c, busy);
            end
            n_checks++;
            if (mode_rdy !== m_rdy) begin
                n_fail++;
                $display("FAIL %s mode_rdy c=%0d: got %b expected %b", tag, c, mode_rdy, m_rdy);
            end
            acc       = mode_vld && m_rdy;
            apply_now = (c == STEP - 1) && !m_rdy;
            tick();
            if (apply_now) model_apply();
            else if (c == STEP - 1) model_advance();
            if (acc) begin
                m_pend = int'(mode);
                m_rdy  = 1'b0;
            end
        end
        mode_vld = 1'b0;
    endtask

    // Idle cycles; optional request at req_at, optional restart on the last one.
    task automatic idle_cycles(input string tag, input int n, input int req_at,
                               input logic [1:0] req_mode, input bit start);
        bit acc;
        bit ap;
        for (int k = 0; k < n; k++) begin
            mode_vld = (k == req_at);
            mode     = req_mode;
            if (start && k == n - 1) en = 1'b1;
            n_checks++;
            if (busy !== 1'b0 || LED_out !== '0 || step_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle k=%0d: got busy=%b led=%b sp=%b expected 0/0000/0",
                         tag, k, busy, LED_out, step_pulse);
            end
            n_checks++;
            if (mode_rdy !== m_rdy) begin
                n_fail++;
                $display("FAIL %s idle mode_rdy k=%0d: got %b expected %b", tag, k, mode_rdy, m_rdy);
            end
            acc = mode_vld && m_rdy;
            ap  = !m_rdy;
            tick();
            if (ap) model_apply();
            if (acc) begin
                m_pend = int'(mode);
                m_rdy  = 1'b0;
            end
        end
        mode_vld = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST      = 1'b1;
        en       = 1'b0;
        mode     = 2'd0;
        mode_vld = 1'b0;
        tick();
        en = 1'b1;   // must not start while reset is held
        tick();
        tick();
        n_checks++;
        if (LED_out !== '0 || step_pulse !== 1'b0 || busy !== 1'b0 || mode_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got led=%b sp=%b busy=%b rdy=%b expected 0000/0/0/1",
                     LED_out, step_pulse, busy, mode_rdy);
        end
        en  = 1'b0;
        RST = 1'b0;
        model_reset();
        idle_cycles("reset_idle", 2, -1, 2'd0, 1'b0);
    endtask

    task automatic test_shift_left();
        logic [N-1:0] seen;
        logic [N-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        idle_cycles("shl_start", 2, -1, 2'd0, 1'b1);
        for (int s = 0; s < 5; s++) begin
            run_step("shl", -1, 2'd0, -1, 2'd0, -1, -1, seen);
            n_checks++;
            if (seen !== exp_seq[s]) begin
                n_fail++;
                $display("FAIL shl_seq step %0d: got %b expected %b", s, seen, exp_seq[s]);
            end
        end
    endtask

    task automatic test_ping_pong();
        logic [N-1:0] seen;
        logic [N-1:0] exp_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                      4'b0100, 4'b0010, 4'b0001, 4'b0010};
        run_step("ping_req", 0, 2'd2, -1, 2'd0, -1, -1, seen);
        for (int s = 0; s < 8; s++) begin
            run_step("ping", -1, 2'd0, -1, 2'd0, -1, -1, seen);
            n_checks++;
            if (seen !== exp_seq[s]) begin
                n_fail++;
                $display("FAIL ping_seq step %0d: got %b expected %b", s, seen, exp_seq[s]);
            end
        end
    endtask

    task automatic test_mode_handshake();
        logic [N-1:0] seen;
        logic [N-1:0] exp_seq [3] = '{4'b1000, 4'b0100, 4'b0010};
        // Request mode 1 at cnt=3; a mode 3 request at cnt=6 must be ignored.
        run_step("hs_req", 3, 2'd1, 6, 2'd3, -1, -1, seen);
        for (int s = 0; s < 3; s++) begin
            run_step("hs", -1, 2'd0, -1, 2'd0, -1, -1, seen);
            n_checks++;
            if (seen !== exp_seq[s]) begin
                n_fail++;
                $display("FAIL hs_seq step %0d: got %b expected %b", s, seen, exp_seq[s]);
            end
        end
    endtask

    task automatic test_stop_resume();
        logic [N-1:0] seen;
        // Drop en at cnt=2: the step drains, then the sequencer idles.
        run_step("stop", -1, 2'd0, -1, 2'd0, 2, -1, seen);
        idle_cycles("stop_idle", 3, -1, 2'd0, 1'b1);
        run_step("resume", -1, 2'd0, -1, 2'd0, -1, -1, seen);
        n_checks++;
        if (seen !== 4'b1000) begin
            n_fail++;
            $display("FAIL resume_next_pos: got %b expected 1000", seen);
        end
        // Mode change while idle is applied right away.
        run_step("stop2", -1, 2'd0, -1, 2'd0, 5, -1, seen);
        idle_cycles("idle_req", 4, 0, 2'd3, 1'b1);
        run_step("all", -1, 2'd0, -1, 2'd0, -1, -1, seen);
        n_checks++;
        if (seen !== 4'b1111) begin
            n_fail++;
            $display("FAIL all_blink: got %b expected 1111", seen);
        end
        // en dropped and restored before the boundary keeps running.
        run_step("stop_abort", -1, 2'd0, -1, 2'd0, 2, 6, seen);
        run_step("after_abort", -1, 2'd0, -1, 2'd0, -1, -1, seen);
    endtask

    task automatic test_async_reset();
        logic [N-1:0] seen;
        logic [N-1:0] pat;
        pat = model_pattern();
        for (int c = 0; c < 4; c++) begin
            mode_vld = (c == 1);
            mode     = 2'd2;
            tick();
        end
        mode_vld = 1'b0;
        n_checks++;
        if (LED_out !== pat) begin
            n_fail++;
            $display("FAIL pre_reset_lit: got %b expected %b", LED_out, pat);
        end
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (LED_out !== '0 || step_pulse !== 1'b0 || busy !== 1'b0 || mode_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got led=%b sp=%b busy=%b rdy=%b expected 0000/0/0/1",
                     LED_out, step_pulse, busy, mode_rdy);
        end
        tick();
        tick();
        RST = 1'b0;
        model_reset();
        tick();
        run_step("post_reset", -1, 2'd0, -1, 2'd0, -1, -1, seen);
        n_checks++;
        if (seen !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_start: got %b expected 0001", seen);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] seen;
        int r, req_at, junk_at, stop_at, reen_at;
        logic [1:0] req_mode, junk_mode;
        for (int it = 0; it < 24; it++) begin
            r         = int'($urandom_range(0, 13));
            req_at    = (r < STEP) ? r : -1;
            r         = int'($urandom_range(0, 13));
            junk_at   = (r < STEP) ? r : -1;
            req_mode  = 2'($urandom_range(0, 3));
            junk_mode = 2'($urandom_range(0, 3));
            stop_at   = -1;
            reen_at   = -1;
            if ($urandom_range(0, 3) == 0) begin
                stop_at = int'($urandom_range(0, STEP - 2));
                if ($urandom_range(0, 1) == 1)
                    reen_at = int'($urandom_range(stop_at + 1, STEP - 1));
            end
            run_step("rand", req_at, req_mode, junk_at, junk_mode, stop_at, reen_at, seen);
            if (stop_at >= 0 && reen_at < 0) begin
                r = int'($urandom_range(0, 3));
                idle_cycles("rand_idle", int'($urandom_range(1, 4)), (r < 2) ? r : -1,
                            2'($urandom_range(0, 3)), 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_left();
        test_ping_pong();
        test_mode_handshake();
        test_stop_resume();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
